// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 80-cell two-line text buffer with cursor control and a registered read port.
// Define LCD_TEXT_SCROLL_EN to scroll the screen up on overflow instead of wrapping the cursor.
module lcd_text_buffer #(
  parameter int         DEPTH    = 80,
  parameter int         LINE_LEN = 40,
  parameter logic [7:0] BLANK    = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [10:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic [6:0]  cursor,
  output logic        busy
);

  localparam logic [6:0] LAST = 7'(DEPTH - 1);
  localparam logic [6:0] LL   = 7'(LINE_LEN);

`ifdef LCD_TEXT_SCROLL_EN
  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_COPY, SCROLL_BLANK} state_t;
`else
  typedef enum logic [1:0] {CLEAR, IDLE} state_t;
`endif

  state_t      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [6:0]  cursor_q, cursor_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  mem_q [DEPTH];
  logic        we;
  logic [6:0]  waddr;
  logic [7:0]  wdata;
  logic        line2;
  logic [6:0]  col;
  logic        printable;
`ifdef LCD_TEXT_SCROLL_EN
  // Cursor value to restore once the scroll sequence has finished.
  logic [6:0]  pend_q, pend_d;
`endif

  assign line2      = (cursor_q >= LL);
  assign col        = line2 ? (cursor_q - LL) : cursor_q;
  assign printable  = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign char_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cursor     = cursor_q;
  assign rd_data    = rd_data_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cursor_d = cursor_q;
    we       = 1'b0;
    waddr    = idx_q;
    wdata    = BLANK;
`ifdef LCD_TEXT_SCROLL_EN
    pend_d   = pend_q;
`endif
    case (state_q)
      CLEAR: begin
        we = 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      IDLE: begin
        if (char_valid) begin
          if (printable) begin
            we    = 1'b1;
            waddr = cursor_q;
            wdata = char_data;
            if (cursor_q == LAST) begin
`ifdef LCD_TEXT_SCROLL_EN
              state_d = SCROLL_COPY;
              idx_d   = '0;
              pend_d  = LL;
`else
              cursor_d = '0;
`endif
            end else begin
              cursor_d = cursor_q + 7'd1;
            end
          end else begin
            case (char_data)
              8'h0D: cursor_d = cursor_q - col;
              8'h0A: begin
                if (!line2) begin
                  cursor_d = cursor_q + LL;
                end else begin
`ifdef LCD_TEXT_SCROLL_EN
                  state_d = SCROLL_COPY;
                  idx_d   = '0;
                  pend_d  = LL + col;
`else
                  cursor_d = col;
`endif
                end
              end
              8'h08: begin
                if (cursor_q != '0) begin
                  cursor_d = cursor_q - 7'd1;
                  we       = 1'b1;
                  waddr    = cursor_q - 7'd1;
                end
              end
              8'h0C: begin
                cursor_d = '0;
                state_d  = CLEAR;
                idx_d    = '0;
              end
              default: ;
            endcase
          end
        end
      end
`ifdef LCD_TEXT_SCROLL_EN
      // One counter sweeps 0..79: copy phase on the low half, blank phase on the high half.
      SCROLL_COPY: begin
        we    = 1'b1;
        wdata = mem_q[idx_q + LL];
        idx_d = idx_q + 7'd1;
        if (idx_q == LL - 7'd1) state_d = SCROLL_BLANK;
      end
      SCROLL_BLANK: begin
        we = 1'b1;
        if (idx_q == LAST) begin
          state_d  = IDLE;
          idx_d    = '0;
          cursor_d = pend_q;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
`endif
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    rd_data_d = (rd_addr < 11'(DEPTH)) ? mem_q[rd_addr[6:0]] : BLANK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      cursor_q  <= '0;
      rd_data_q <= BLANK;
`ifdef LCD_TEXT_SCROLL_EN
      pend_q    <= LL;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cursor_q  <= cursor_d;
      rd_data_q <= rd_data_d;
`ifdef LCD_TEXT_SCROLL_EN
      pend_q    <= pend_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

endmodule
